// File: rtl/core_inst_pkg.sv
// Shared encodings for the core instruction sequencer: instruction bit map, idle word and FSM states.
package core_inst_pkg;

   localparam int INST_W = 35;
   localparam int ADDR_W = 11;

   localparam int INST_ACC       = 33;
   localparam int INST_CEN_PMEM  = 32;
   localparam int INST_WEN_PMEM  = 31;
   localparam int INST_A_PMEM_LO = 20;
   localparam int INST_CEN_XMEM  = 19;
   localparam int INST_WEN_XMEM  = 18;
   localparam int INST_A_XMEM_LO = 7;
   localparam int INST_OFIFO_RD  = 6;
   localparam int INST_IFIFO_WR  = 5;
   localparam int INST_IFIFO_RD  = 4;
   localparam int INST_L0_RD     = 3;
   localparam int INST_L0_WR     = 2;
   localparam int INST_EXECUTE   = 1;
   localparam int INST_LOAD      = 0;

   // All memory enables deasserted (active-low), everything else quiet.
   localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [INST_W-1:0] inst_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_K_RST,
      S_W_L0,
      S_K_LOAD,
      S_X_L0,
      S_EXEC,
      S_DRAIN,
      S_GAP,
      S_A_RST,
      S_A_RD,
      S_A_END,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/core_inst_sequencer_if.sv
// Host/core side of the sequencer: start strobe in; instruction word, core reset and result strobes out.
interface core_inst_sequencer_if;
   import core_inst_pkg::*;

   logic              start;
   logic              busy;
   logic              done;
   logic [INST_W-1:0] inst;
   logic              core_reset;
   logic              out_strobe;
   logic [3:0]        onij_idx;

   modport master (
      input  start,
      output busy,
      output done,
      output inst,
      output core_reset,
      output out_strobe,
      output onij_idx
   );

   modport slave (
      output start,
      input  busy,
      input  done,
      input  inst,
      input  core_reset,
      input  out_strobe,
      input  onij_idx
   );

endinterface

// File: rtl/seq_acc_addr_gen.sv
// Accumulation-pass psum read address: j*len_nij + (orow+kr)*IW + (ocol+kc), one cycle registered.
// Tap pair (kr,kc) walks with step/clear; output pair (orow,ocol) walks with o_step/o_clear.
module seq_acc_addr_gen
   import core_inst_pkg::*;
#(
   parameter int KS      = 3,
   parameter int IW      = 6,
   parameter int OW      = 4,
   parameter int LEN_NIJ = 36
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  clear,
   input  logic  step,
   input  logic  o_clear,
   input  logic  o_step,
   output addr_t addr
);

   localparam logic [3:0] KS_LAST = 4'(KS - 1);
   localparam logic [3:0] OW_LAST = 4'(OW - 1);

   logic [3:0] kr, kc, orow, ocol;
   addr_t      base;
   addr_t      row_sum;
   addr_t      addr_nxt;

   // base tracks j*len_nij incrementally so no multiplier is needed on the tap index.
   assign row_sum  = addr_t'(orow) + addr_t'(kr);
   assign addr_nxt = base + row_sum * addr_t'(IW) + addr_t'(ocol) + addr_t'(kc);

   always_ff @(posedge clk) begin
      if (!reset) begin
         addr <= '0;
         base <= '0;
         kr   <= '0;
         kc   <= '0;
         orow <= '0;
         ocol <= '0;
      end else begin
         addr <= addr_nxt;

         if (clear) begin
            base <= '0;
            kr   <= '0;
            kc   <= '0;
         end else if (step) begin
            base <= base + addr_t'(LEN_NIJ);
            if (kc == KS_LAST) begin
               kc <= '0;
               kr <= kr + 4'd1;
            end else begin
               kc <= kc + 4'd1;
            end
         end

         if (o_clear) begin
            orow <= '0;
            ocol <= '0;
         end else if (o_step) begin
            if (ocol == OW_LAST) begin
               ocol <= '0;
               orow <= orow + 4'd1;
            end else begin
               ocol <= ocol + 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/core_inst_sequencer.sv
// Drives the core instruction bus through conv (all kij) then accumulation (all onij) from one start strobe.
// Outputs are registered: fields of state S appear on inst the cycle after S is entered; start only taken in IDLE.
module core_inst_sequencer
   import core_inst_pkg::*;
#(
   parameter int ROW      = 8,
   parameter int COL      = 8,
   parameter int LEN_KIJ  = 9,
   parameter int KS       = 3,
   parameter int IW       = 6,
   parameter int LEN_NIJ  = 36,
   parameter int OW       = 4,
   parameter int LEN_ONIJ = 16,
   parameter int W_BASE   = 1024,
   parameter int GAP      = 2,
   parameter int RST_CYC  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   core_inst_sequencer_if.master bus
);

   localparam logic [7:0] C_RST_END  = 8'(RST_CYC - 1);
   localparam logic [7:0] C_COL_END  = 8'(COL - 1);
   localparam logic [7:0] C_NIJ      = 8'(LEN_NIJ);
   localparam logic [7:0] C_NIJ_END  = 8'(LEN_NIJ - 1);
   localparam logic [7:0] C_EXEC_END = 8'(LEN_NIJ + ROW + COL - 1);
   localparam logic [7:0] C_GAP_END  = 8'(GAP - 1);
   localparam logic [7:0] C_KIJ      = 8'(LEN_KIJ);
   localparam logic [7:0] C_KIJ_LAST = 8'(LEN_KIJ - 1);
   localparam logic [3:0] K_LAST     = 4'(LEN_KIJ - 1);
   localparam logic [3:0] O_LAST     = 4'(LEN_ONIJ - 1);

   seq_state_t state, state_nxt;
   seq_state_t ret, ret_nxt;
   logic [7:0] cnt;
   logic [3:0] k, o;
   inst_t      inst_q, inst_nxt;
   logic       acc_rd, acc_rd_q;
   logic       busy_q, done_q, core_reset_q, out_strobe_q;
   logic [3:0] onij_q;
   logic       start_ok;
   addr_t      w_addr, p_addr, acc_addr;
   logic       acc_clear, acc_step, o_clear, o_step;

   // done_q blocks a start that lands on the completion pulse.
   assign start_ok = bus.start && !done_q;

   assign w_addr = addr_t'(W_BASE) + addr_t'(k) * addr_t'(COL) + addr_t'(cnt);
   assign p_addr = addr_t'(k) * addr_t'(LEN_NIJ) + addr_t'(cnt) - addr_t'(1);

   assign acc_clear = (state == S_A_RST);
   assign acc_step  = (state == S_A_RD) && (cnt < C_KIJ_LAST);
   assign o_clear   = (state == S_IDLE);
   assign o_step    = (state == S_A_END) && (state_nxt == S_A_RST);

   seq_acc_addr_gen #(
      .KS      (KS),
      .IW      (IW),
      .OW      (OW),
      .LEN_NIJ (LEN_NIJ)
   ) u_acc_addr (
      .clk     (clk),
      .reset   (reset),
      .clear   (acc_clear),
      .step    (acc_step),
      .o_clear (o_clear),
      .o_step  (o_step),
      .addr    (acc_addr)
   );

   always_comb begin
      state_nxt = state;
      ret_nxt   = ret;
      inst_nxt  = INST_IDLE;
      acc_rd    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start_ok) state_nxt = S_K_RST;
         end
         S_K_RST: begin
            if (cnt == C_RST_END) begin
               state_nxt = S_GAP;
               ret_nxt   = S_W_L0;
            end
         end
         S_W_L0: begin
            inst_nxt[INST_CEN_XMEM]               = 1'b0;
            inst_nxt[INST_L0_WR]                  = 1'b1;
            inst_nxt[INST_A_XMEM_LO +: ADDR_W]    = w_addr;
            if (cnt == C_COL_END) begin
               state_nxt = S_GAP;
               ret_nxt   = S_K_LOAD;
            end
         end
         S_K_LOAD: begin
            inst_nxt[INST_L0_RD] = 1'b1;
            inst_nxt[INST_LOAD]  = 1'b1;
            if (cnt == C_COL_END) begin
               state_nxt = S_GAP;
               ret_nxt   = S_X_L0;
            end
         end
         S_X_L0: begin
            inst_nxt[INST_CEN_XMEM]               = 1'b0;
            inst_nxt[INST_L0_WR]                  = 1'b1;
            inst_nxt[INST_A_XMEM_LO +: ADDR_W]    = addr_t'(cnt);
            if (cnt == C_NIJ_END) begin
               state_nxt = S_GAP;
               ret_nxt   = S_EXEC;
            end
         end
         S_EXEC: begin
            // Trailing row+col cycles let the array flush into the OFIFO.
            if (cnt < C_NIJ) begin
               inst_nxt[INST_L0_RD]   = 1'b1;
               inst_nxt[INST_EXECUTE] = 1'b1;
            end
            if (cnt == C_EXEC_END) begin
               state_nxt = S_GAP;
               ret_nxt   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cnt < C_NIJ) inst_nxt[INST_OFIFO_RD] = 1'b1;
            if (cnt != 8'd0) begin
               inst_nxt[INST_CEN_PMEM]            = 1'b0;
               inst_nxt[INST_WEN_PMEM]            = 1'b0;
               inst_nxt[INST_A_PMEM_LO +: ADDR_W] = p_addr;
            end
            if (cnt == C_NIJ) begin
               state_nxt = S_GAP;
               ret_nxt   = (k == K_LAST) ? S_A_RST : S_K_RST;
            end
         end
         S_GAP: begin
            if (cnt == C_GAP_END) state_nxt = ret;
         end
         S_A_RST: begin
            state_nxt = S_A_RD;
         end
         S_A_RD: begin
            // Read data lands one cycle later, so acc trails the reads by one.
            if (cnt < C_KIJ) begin
               inst_nxt[INST_CEN_PMEM] = 1'b0;
               acc_rd                  = 1'b1;
            end
            if (cnt != 8'd0) inst_nxt[INST_ACC] = 1'b1;
            if (cnt == C_KIJ) state_nxt = S_A_END;
         end
         S_A_END: begin
            state_nxt = (o == O_LAST) ? S_DONE : S_A_RST;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= S_IDLE;
         ret          <= S_IDLE;
         cnt          <= '0;
         k            <= '0;
         o            <= '0;
         inst_q       <= INST_IDLE;
         acc_rd_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         core_reset_q <= 1'b0;
         out_strobe_q <= 1'b0;
         onij_q       <= '0;
      end else begin
         state <= state_nxt;
         ret   <= ret_nxt;
         cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;

         if (state == S_IDLE) begin
            k <= '0;
         end else if (state == S_DRAIN && state_nxt != S_DRAIN && k != K_LAST) begin
            k <= k + 4'd1;
         end

         if (state == S_IDLE) begin
            o <= '0;
         end else if (o_step) begin
            o <= o + 4'd1;
         end

         inst_q       <= inst_nxt;
         acc_rd_q     <= acc_rd;
         busy_q       <= (state != S_IDLE) && (state != S_DONE);
         done_q       <= (state == S_DONE);
         core_reset_q <= (state == S_K_RST) || (state == S_A_RST);
         out_strobe_q <= (state == S_A_END);
         if (state == S_A_END) onij_q <= o;
      end
   end

   // The accumulation read address is already registered in the generator, aligned with inst_q.
   assign bus.inst = acc_rd_q ?
                     {inst_q[INST_W-1:INST_A_PMEM_LO+ADDR_W], acc_addr, inst_q[INST_A_PMEM_LO-1:0]} :
                     inst_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.core_reset = core_reset_q;
   assign bus.out_strobe = out_strobe_q;
   assign bus.onij_idx   = onij_q;

endmodule
